// File: rtl/timer_pkg.sv
// Shared constants for the multi-channel APB timer: register map,
// TCR/TSR bit positions and the prescaler divide helper.
package timer_pkg;

   localparam int CH_STRIDE = 16;
   localparam int CH_LSB    = $clog2(CH_STRIDE);
   localparam int CLK_SEL_W = 3;

   localparam logic [3:0] OFF_TCR  = 4'h0;
   localparam logic [3:0] OFF_TDR  = 4'h4;
   localparam logic [3:0] OFF_TCNT = 4'h8;
   localparam logic [3:0] OFF_TSR  = 4'hC;

   localparam int TCR_LOAD   = 7;
   localparam int TCR_ARLD   = 6;
   localparam int TCR_DW     = 5;
   localparam int TCR_EN     = 4;
   localparam int TCR_OVF_IE = 8;
   localparam int TCR_UDF_IE = 9;
   localparam int TCR_W      = 10;

   // Bit 3 is reserved and never stored, so it always reads back 0.
   localparam logic [TCR_W-1:0] TCR_WMASK = 10'h3F7;

   localparam int TSR_OVF = 0;
   localparam int TSR_UDF = 1;

   // Low clk_sel+1 bits set: the prescaler ticks when these bits are all ones.
   function automatic logic [7:0] pre_mask(input logic [CLK_SEL_W-1:0] sel);
      return 8'((9'd2 << sel) - 9'd1);
   endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: TCR/TDR/TCNT/TSR registers, 8-bit prescaler,
// up/down counter with optional auto-reload and a registered interrupt.
module timer_channel
   import timer_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             pclk,
   input  logic             preset,
   input  logic             wr_tcr,
   input  logic             wr_tdr,
   input  logic             wr_tsr,
   input  logic [31:0]      wdata,
   output logic [TCR_W-1:0] tcr,
   output logic [CNT_W-1:0] tdr,
   output logic [CNT_W-1:0] tcnt,
   output logic [1:0]       tsr,
   output logic             irq
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [7:0]           pre;
   logic [CLK_SEL_W-1:0] clk_sel;
   logic                 run;
   logic                 tick;
   logic [1:0]           hw_set;
   logic                 unused_wdata;

   assign clk_sel = tcr[CLK_SEL_W-1:0];
   assign run     = tcr[TCR_EN] & ~tcr[TCR_LOAD];
   assign tick    = run & ((pre & pre_mask(clk_sel)) == pre_mask(clk_sel));

   assign hw_set[TSR_OVF] = tick & ~tcr[TCR_DW] & (tcnt == CNT_MAX);
   assign hw_set[TSR_UDF] = tick &  tcr[TCR_DW] & (tcnt == '0);

   assign unused_wdata = ^wdata[31:TCR_W];

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         pre  <= '0;
         tcr  <= '0;
         tdr  <= '0;
         tcnt <= '0;
         tsr  <= '0;
         irq  <= 1'b0;
      end else begin
         // pre is never cleared by a clk_sel change, only by stopping or loading.
         pre <= run ? pre + 8'd1 : 8'd0;

         if (wr_tcr) tcr <= wdata[TCR_W-1:0] & TCR_WMASK;
         if (wr_tdr) tdr <= wdata[CNT_W-1:0];

         if (tcr[TCR_LOAD]) begin
            tcnt <= tdr;
         end else if (tick) begin
            if (tcr[TCR_DW])
               tcnt <= hw_set[TSR_UDF] ? (tcr[TCR_ARLD] ? tdr : CNT_MAX)
                                       : tcnt - CNT_W'(1);
            else
               tcnt <= hw_set[TSR_OVF] ? (tcr[TCR_ARLD] ? tdr : '0)
                                       : tcnt + CNT_W'(1);
         end

         // Software can only clear (write 0); a same-cycle hardware set wins.
         tsr <= (wr_tsr ? (tsr & wdata[1:0]) : tsr) | hw_set;
         irq <= (tsr[TSR_OVF] & tcr[TCR_OVF_IE]) | (tsr[TSR_UDF] & tcr[TCR_UDF_IE]);
      end
   end

endmodule

// File: rtl/timer_multi_ch.sv
// Multi-channel APB timer top: address decode, pslverr and read mux over
// N_CH timer_channel instances.
// APB: setup phase is psel&~penable, access phase is psel&penable; pready is
// always 1, so every access phase completes and a write commits on its edge.
module timer_multi_ch
   import timer_pkg::*;
#(
   parameter int N_CH   = 4,
   parameter int CNT_W  = 8,
   parameter int ADDR_W = 8
) (
   input  logic              pclk,
   input  logic              preset,
   input  logic              psel,
   input  logic              penable,
   input  logic              pwrite,
   input  logic [ADDR_W-1:0] paddr,
   input  logic [31:0]       pwdata,
   output logic [31:0]       prdata,
   output logic              pready,
   output logic              pslverr,
   output logic [N_CH-1:0]   irq
);

   logic [2:0]       ch;
   logic [3:0]       off;
   logic             access;
   logic             ch_bad;
   logic             off_bad;
   logic             err;
   logic             wr_ok;
   logic             unused_paddr;

   logic [TCR_W-1:0] tcr_a  [N_CH];
   logic [CNT_W-1:0] tdr_a  [N_CH];
   logic [CNT_W-1:0] tcnt_a [N_CH];
   logic [1:0]       tsr_a  [N_CH];

   assign ch           = paddr[CH_LSB +: 3];
   assign off          = paddr[CH_LSB-1:0];
   assign unused_paddr = ^paddr[ADDR_W-1:CH_LSB+3];

   assign access  = psel & penable;
   assign ch_bad  = (32'(ch) >= 32'(N_CH));
   assign off_bad = !(off inside {OFF_TCR, OFF_TDR, OFF_TCNT, OFF_TSR});
   assign err     = ch_bad | off_bad | (pwrite & (off == OFF_TCNT));
   assign pslverr = access & err;
   assign pready  = 1'b1;
   assign wr_ok   = access & pwrite & ~err;

   for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      logic sel;
      assign sel = wr_ok & (ch == 3'(gi));

      timer_channel #(.CNT_W(CNT_W)) u_ch (
         .pclk   (pclk),
         .preset (preset),
         .wr_tcr (sel & (off == OFF_TCR)),
         .wr_tdr (sel & (off == OFF_TDR)),
         .wr_tsr (sel & (off == OFF_TSR)),
         .wdata  (pwdata),
         .tcr    (tcr_a[gi]),
         .tdr    (tdr_a[gi]),
         .tcnt   (tcnt_a[gi]),
         .tsr    (tsr_a[gi]),
         .irq    (irq[gi])
      );
   end

   // Reads of a bad address return 0; outside a read access phase prdata is 0.
   always_comb begin
      prdata = '0;
      if (access & ~pwrite & ~err) begin
         for (int i = 0; i < N_CH; i++) begin
            if (ch == 3'(i)) begin
               case (off)
                  OFF_TCR:  prdata = 32'(tcr_a[i]);
                  OFF_TDR:  prdata = 32'(tdr_a[i]);
                  OFF_TCNT: prdata = 32'(tcnt_a[i]);
                  OFF_TSR:  prdata = 32'(tsr_a[i]);
                  default:  prdata = '0;
               endcase
            end
         end
      end
   end

endmodule
